// File: rtl/rsa_rfid_pkg.sv
// Shared definitions for the RSA RFID datapath.
// Provides the framer state encoding, EPC Gen2 CRC-16 constants and a
// single-bit CRC-16 step function used by both the serial CRC engine and
// the framer when it pre-computes the final (inverted) CRC.
package rsa_rfid_pkg;

    localparam int unsigned CRC16_WIDTH   = 16;
    localparam logic [15:0] CRC16_POLY    = 16'h1021;
    localparam logic [15:0] CRC16_PRESET  = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUE = 16'h1D0F;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StCrc,
        StFin
    } tx_state_e;

    // One MSB-first CRC-16 (x^16 + x^12 + x^5 + 1) step for input bit din.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/crc16_serial.sv
// Bit-serial EPC Gen2 CRC-16 engine.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-high reset (register -> preset)
//   init  - synchronous preset to 0xFFFF (takes priority over en)
//   en    - advance the CRC by one bit
//   din   - input bit consumed when en is high
//   crc   - current CRC register value
module crc16_serial
    import rsa_rfid_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic [15:0] crc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_q <= CRC16_PRESET;
        end else if (init) begin
            crc_q <= CRC16_PRESET;
        end else if (en) begin
            crc_q <= crc16_step(crc_q, din);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/rsa_tx_framer.sv
// Backscatter framer for the RSA RFID core.
// Captures the RSA result on start, appends the inverted CRC-16 and
// serialises the WordSize+16 bit frame MSB-first, ClkDiv cycles per bit.
// Ports:
//   clk, reset  - clock (rising edge) and asynchronous active-high reset
//   start       - capture strobe, accepted only while ready
//   data_in     - result word sampled on an accepted start
//   ready       - idle, a start will be accepted
//   busy        - frame in progress (DATA, CRC or FIN)
//   tx_bit      - current serial bit (0 outside DATA/CRC)
//   tx_valid    - pulse on the first cycle of every bit period
//   frame_done  - pulse in the single FIN cycle after the last bit
module rsa_tx_framer
    import rsa_rfid_pkg::*;
#(
    parameter int unsigned WordSize = 32,
    parameter int unsigned ClkDiv   = 4,
    parameter int unsigned CrcWidth = CRC16_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WordSize-1:0] data_in,
    output logic                ready,
    output logic                busy,
    output logic                tx_bit,
    output logic                tx_valid,
    output logic                frame_done
);

    localparam int unsigned DivW = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
    localparam int unsigned BitW = $clog2(WordSize + CrcWidth);

    tx_state_e             state_q, state_d;
    logic [WordSize-1:0]   shift_q, shift_d;
    logic [CrcWidth-1:0]   crc_shift_q, crc_shift_d;
    logic [DivW-1:0]       div_q, div_d;
    logic [BitW-1:0]       bit_q, bit_d;
    logic                  crc_init, crc_en;
    logic [15:0]           crc;
    logic                  div_last;

    crc16_serial u_crc (
        .clk   (clk),
        .reset (reset),
        .init  (crc_init),
        .en    (crc_en),
        .din   (shift_q[WordSize-1]),
        .crc   (crc)
    );

    assign div_last = (div_q == DivW'(ClkDiv - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            crc_shift_q <= '0;
            div_q       <= '0;
            bit_q       <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            crc_shift_q <= crc_shift_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        crc_shift_d = crc_shift_q;
        div_d       = div_q;
        bit_d       = bit_q;
        crc_init    = 1'b0;
        crc_en      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    shift_d  = data_in;
                    crc_init = 1'b1;
                    div_d    = '0;
                    bit_d    = '0;
                    state_d  = StData;
                end
            end
            StData: begin
                div_d = div_last ? '0 : div_q + 1'b1;
                if (div_last) begin
                    shift_d = {shift_q[WordSize-2:0], 1'b0};
                    crc_en  = 1'b1;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BitW'(WordSize - 1)) begin
                        // The CRC register only absorbs the last data bit at this
                        // edge, so fold that bit in here before inverting.
                        crc_shift_d = ~crc16_step(crc, shift_q[WordSize-1]);
                        state_d     = StCrc;
                    end
                end
            end
            StCrc: begin
                div_d = div_last ? '0 : div_q + 1'b1;
                if (div_last) begin
                    crc_shift_d = {crc_shift_q[CrcWidth-2:0], 1'b0};
                    if (bit_q == BitW'(WordSize + CrcWidth - 1)) begin
                        bit_d   = '0;
                        state_d = StFin;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        ready      = (state_q == StIdle);
        busy       = (state_q != StIdle);
        tx_bit     = 1'b0;
        tx_valid   = 1'b0;
        frame_done = (state_q == StFin);
        if (state_q == StData) begin
            tx_bit   = shift_q[WordSize-1];
            tx_valid = (div_q == '0);
        end else if (state_q == StCrc) begin
            tx_bit   = crc_shift_q[CrcWidth-1];
            tx_valid = (div_q == '0);
        end
    end

endmodule

// File: doc/rsa_tx_framer.md
Name: rsa_tx_framer

Overview:
- Downstream stage of the RSA RFID core.
- On the core's done pulse it captures the WordSize-bit output_text, appends an EPC Gen2 CRC-16 and serialises the frame MSB-first as the tag backscatter bitstream.
- A programmable clocks-per-bit divider sets the bit period; busy/ready indicate whether a new result can be accepted.

Parameters:
- WordSize, 32, width of the captured RSA result word.
- ClkDiv, 4, clock cycles per transmitted bit (legal range >= 1).
- CrcWidth, 16, CRC length; fixed at 16, exposed for the shared package only.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle capture strobe, driven by the RSA core done.
- data_in  input  WordSize  RSA output_text; sampled only on an accepted start.
- ready  output  1  high when IDLE and a start will be accepted.
- busy  output  1  high while a frame is in progress (DATA, CRC or FIN state).
- tx_bit  output  1  current serial bit, held for ClkDiv cycles.
- tx_valid  output  1  one-cycle pulse on the first cycle of each bit period.
- frame_done  output  1  one-cycle pulse when the final bit period ends.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: ready=1, busy=0, tx_bit=0, tx_valid=0, frame_done=0; shift register 0, CRC register 0xFFFF, counters 0, state IDLE.
- Reset mid-frame aborts immediately. No partial-frame completion and no frame_done.
- States: IDLE -> DATA -> CRC -> FIN -> IDLE.
- IDLE:
  - start=1 at edge t latches data_in, presets the CRC to 0xFFFF, clears the bit and divider counters and goes to DATA.
  - start while not IDLE is ignored; no queueing.
- DATA:
  - tx_bit = shift[WordSize-1].
  - tx_valid is pulsed when the divider count is 0.
  - The divider counts 0..ClkDiv-1.
  - At count ClkDiv-1 the register shifts left by 1 and the CRC steps: fb = crc[15]^bit; crc = {crc[14:0],1'b0} ^ (fb ? 16'h1021 : 0).
  - After WordSize bits, load the CRC shift register with ~crc and go to CRC.
- CRC:
  - Sends the 16 inverted CRC bits MSB-first with the same divider and tx_valid rules.
  - After the 16th bit period go to FIN.
- FIN:
  - Single cycle: frame_done=1, tx_bit=0; next state IDLE.
- Timing:
  - Start sampled at edge t gives the tx_valid for bit 0 at cycle t+1.
  - Bit k starts at t+1+k*ClkDiv, for k = 0..WordSize+15.
  - frame_done occurs at t+1+(WordSize+16)*ClkDiv.
  - ready returns at the following cycle.
- ClkDiv=1: tx_valid stays high for every DATA/CRC cycle, and each bit lasts exactly one cycle.
- Back-to-back operation: start asserted in the cycle ready returns is accepted. The minimum frame spacing is (WordSize+16)*ClkDiv+2 cycles.
- tx_bit outside DATA/CRC is 0.
- Widths:
  - The divider counter is $clog2(ClkDiv) bits, minimum 1.
  - The bit counter is $clog2(WordSize+16) bits.
  - No arithmetic overflow is possible.

Decomposition:
- Shared package (rsa_rfid_pkg):
  - state typedef {IDLE, DATA, CRC, FIN}.
  - CRC16_POLY = 16'h1021.
  - CRC16_PRESET = 16'hFFFF.
  - CRC16_RESIDUE = 16'h1D0F.
- One sub-module, crc16_serial:
  - Inputs: clk, reset, init, en, din.
  - Output: crc[15:0].
  - Reused later by the upstream RFID command receiver for its CRC check.

Test Plan:
- Reset mid-DATA (bit 10, ClkDiv=4), then deassert -> all outputs at reset values within the same cycle, no frame_done. Then start with data_in=0xA5A5A5A5 -> a clean full frame.
- ClkDiv=4, start with data_in=0x80000001 at edge t:
  - first tx_valid at t+1 with tx_bit=1.
  - bit 1 at t+5 with tx_bit=0.
  - bit 31 at t+125 with tx_bit=1.
  - frame_done at t+193.
- data_in=0x12345678: bench-side serial CRC over the 48 received bits (32 data + 16 CRC), preset 0xFFFF -> remainder equals 0x1D0F. Repeat for 0x00000000 and 0xFFFFFFFF.
- Start pulsed again at bits 3 and 40 of an active frame with different data_in -> ignored. The transmitted frame matches the first data, and ready stays 0 until FIN.
- ClkDiv=1, two frames back-to-back with start held high:
  - tx_valid high for 48 consecutive cycles each frame.
  - frame_done pulses exactly 50 cycles apart.
  - The second frame carries the data_in sampled in the ready cycle.
